// File: rtl/rv_muldiv_pkg.sv
// Shared definitions for the RV M-extension multiply/divide unit.
// The funct3 encodings of the M-extension operations, with small decode helpers.
package rv_muldiv_pkg;

   localparam logic [2:0] FUNCT_MUL    = 3'd0;
   localparam logic [2:0] FUNCT_MULH   = 3'd1;
   localparam logic [2:0] FUNCT_MULHSU = 3'd2;
   localparam logic [2:0] FUNCT_MULHU  = 3'd3;
   localparam logic [2:0] FUNCT_DIV    = 3'd4;
   localparam logic [2:0] FUNCT_DIVU   = 3'd5;
   localparam logic [2:0] FUNCT_REM    = 3'd6;
   localparam logic [2:0] FUNCT_REMU   = 3'd7;

   function automatic logic is_mul(input logic [2:0] op);
      return ~op[2];
   endfunction

   // Meaningful for divide ops only: DIV and REM are signed, DIVU and REMU are not.
   function automatic logic div_signed(input logic [2:0] op);
      return ~op[0];
   endfunction

   function automatic logic div_rem(input logic [2:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/rv_muldiv.sv
// RV M-extension multiply/divide unit: single-cycle multiply, XLEN-cycle restoring
// divide, one operation in flight, valid/ready on both sides, synchronous kill.
module rv_muldiv
   import rv_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result
);

   localparam int              CW       = $clog2(XLEN);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = '1;
   localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN-1);

   typedef enum logic [1:0] {IDLE, SHORT, DIV, DONE} state_e;

   state_e          state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d;
   logic [XLEN-1:0] quot_q, quot_d, rem_q, rem_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [XLEN-1:0]   in_a_mag, b_mag, quot_next, rem_next, div_result, short_result;
   logic [XLEN:0]     rem_shift, diff;
   logic              step_ge, neg_quot, neg_rem;
   logic [2*XLEN-1:0] mul_a, mul_b, product;

   function automatic logic is_ovf(input logic [2:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
      return !is_mul(op) && div_signed(op) && a == MOST_NEG && b == ALL_ONES;
   endfunction

   function automatic logic is_short(input logic [2:0] op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
      return is_mul(op) || b == '0 || is_ovf(op, a, b);
   endfunction

   // NOTE: combinational blocks use blocking '=' and assign every output first thing
   // on every path, so no latch is inferred and reads see the value just computed.
   always_comb begin
      in_a_mag  = (div_signed(in_op) && in_a[XLEN-1]) ? -in_a : in_a;
      b_mag     = (div_signed(op_q) && b_q[XLEN-1]) ? -b_q : b_q;

      // One restoring step: the dividend shifts out of quot_q's top while quotient bits shift in.
      rem_shift = {rem_q, quot_q[XLEN-1]};
      diff      = rem_shift - {1'b0, b_mag};
      step_ge   = ~diff[XLEN];
      rem_next  = step_ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
      quot_next = {quot_q[XLEN-2:0], step_ge};

      neg_quot  = div_signed(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
      neg_rem   = div_signed(op_q) && a_q[XLEN-1];
      if (div_rem(op_q)) div_result = neg_rem  ? -rem_next  : rem_next;
      else               div_result = neg_quot ? -quot_next : quot_next;

      mul_a   = {{XLEN{(op_q != FUNCT_MULHU) && a_q[XLEN-1]}}, a_q};
      mul_b   = {{XLEN{(op_q == FUNCT_MUL || op_q == FUNCT_MULH) && b_q[XLEN-1]}}, b_q};
      product = mul_a * mul_b;

      if (is_mul(op_q))
         short_result = (op_q == FUNCT_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
      else if (b_q == '0)
         short_result = div_rem(op_q) ? a_q : ALL_ONES;
      else
         short_result = div_rem(op_q) ? '0 : MOST_NEG;
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      result_d = result_q;

      unique case (state_q)
         IDLE: if (in_valid) begin
            op_d    = in_op;
            a_d     = in_a;
            b_d     = in_b;
            quot_d  = in_a_mag;
            rem_d   = '0;
            cnt_d   = CNT_LOAD;
            state_d = is_short(in_op, in_a, in_b) ? SHORT : DIV;
         end
         SHORT: begin
            result_d = short_result;
            state_d  = DONE;
         end
         DIV: begin
            quot_d = quot_next;
            rem_d  = rem_next;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               result_d = div_result;
               state_d  = DONE;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Kill beats acceptance, completion and the output handshake alike.
      if (kill) begin
         state_d  = IDLE;
         op_d     = op_q;
         a_d      = a_q;
         b_d      = b_q;
         result_d = result_q;
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so every register samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         quot_q   <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign out_result = result_q;

endmodule

// File: tb/tb_rv_muldiv.sv
// Self-checking bench for rv_muldiv: a vector table for results and latencies, plus
// hand-written sequences for back-pressure, kill, reset and the 64-bit build.
module tb_rv_muldiv;
   import rv_muldiv_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, kill, out_ready, in_ready, out_valid;
   logic [2:0]  in_op;
   logic [31:0] in_a, in_b, out_result;

   logic        v64, k64, or64, ready64, ov64;
   logic [2:0]  op64;
   logic [63:0] a64, b64, res64;

   int checks = 0;
   int errors = 0;

   rv_muldiv #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result)
   );

   rv_muldiv #(.XLEN(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(ready64), .in_op(op64),
      .in_a(a64), .in_b(b64), .kill(k64), .out_valid(ov64), .out_ready(or64),
      .out_result(res64)
   );

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives one request, then scrambles the inputs right after the accepting edge.
   task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0; in_op = ~op; in_a = ~a; in_b = b + 32'd1;
   endtask

   // n counts edges with the accepting edge as 1; busy_ok drops if in_ready rises early.
   task automatic wait_valid(input int limit, output int n, output bit busy_ok);
      n = 1; busy_ok = 1'b1;
      while (!out_valid && n < limit) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic drain();
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
   endtask

   task automatic watch_quiet(input string name, input int cycles);
      bit quiet = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (out_valid) quiet = 1'b0;
      end
      check(name, quiet, 1'b1);
   endtask

   task automatic run64(input string name, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat);
      int n;
      @(negedge clk);
      v64 = 1'b1; op64 = op; a64 = a; b64 = b;
      @(posedge clk); #1;
      v64 = 1'b0; a64 = '0; b64 = '0;
      n = 1;
      while (!ov64 && n < lat + 8) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, " latency"}, 64'(n), 64'(lat));
      check({name, " result"}, res64, exp);
      @(negedge clk); or64 = 1'b1;
      @(posedge clk); #1; or64 = 1'b0;
   endtask

   initial begin
      int  n;
      bit  busy_ok, held_ok;

      rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
      in_op = '0; in_a = '0; in_b = '0;
      v64 = 1'b0; k64 = 1'b0; or64 = 1'b0; op64 = '0; a64 = '0; b64 = '0;

      vecs.push_back('{"MUL 7*-3",      FUNCT_MUL,    32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2});
      vecs.push_back('{"MULH min*min",  FUNCT_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 2});
      vecs.push_back('{"MULHU ones",    FUNCT_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2});
      vecs.push_back('{"MULHSU ones",   FUNCT_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2});
      vecs.push_back('{"MULHU 2^31*2",  FUNCT_MULHU,  32'h80000000, 32'h2,        32'h1,        2});
      vecs.push_back('{"MUL 2^16*2^16", FUNCT_MUL,    32'h10000,    32'h10000,    32'h0,        2});
      vecs.push_back('{"DIV -7/2",      FUNCT_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33});
      vecs.push_back('{"REM -7/2",      FUNCT_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33});
      vecs.push_back('{"DIVU 100/7",    FUNCT_DIVU,   32'd100,      32'd7,        32'd14,       33});
      vecs.push_back('{"REMU 100/7",    FUNCT_REMU,   32'd100,      32'd7,        32'd2,        33});
      vecs.push_back('{"DIV 20/-3",     FUNCT_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33});
      vecs.push_back('{"REM -20/3",     FUNCT_REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33});
      vecs.push_back('{"DIVU min/ones", FUNCT_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h0,        33});
      vecs.push_back('{"REMU min/ones", FUNCT_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});
      vecs.push_back('{"DIV min/1",     FUNCT_DIV,    32'h80000000, 32'h1,        32'h80000000, 33});
      vecs.push_back('{"DIV 5/0",       FUNCT_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 2});
      vecs.push_back('{"DIVU 5/0",      FUNCT_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 2});
      vecs.push_back('{"REM 7/0",       FUNCT_REM,    32'd7,        32'd0,        32'd7,        2});
      vecs.push_back('{"REMU 5/0",      FUNCT_REMU,   32'd5,        32'd0,        32'd5,        2});
      vecs.push_back('{"DIV ovf",       FUNCT_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2});
      vecs.push_back('{"REM ovf",       FUNCT_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        2});

      #1;
      check("reset in_ready", in_ready, 1'b1);
      check("reset out_valid", out_valid, 1'b0);
      check("reset out_result", out_result, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         start(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_valid(vecs[i].lat + 8, n, busy_ok);
         check({vecs[i].name, " latency"}, 64'(n), 64'(vecs[i].lat));
         check({vecs[i].name, " result"}, out_result, vecs[i].exp);
         check({vecs[i].name, " busy"}, busy_ok, 1'b1);
         drain();
         check({vecs[i].name, " idle"}, in_ready, 1'b1);
      end

      // Back-pressure in DONE, then accept on the edge after the handshake.
      start(FUNCT_MUL, 32'd6, 32'd7);
      wait_valid(10, n, busy_ok);
      held_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (!out_valid || out_result !== 32'd42 || in_ready) held_ok = 1'b0;
      end
      check("hold stable", held_ok, 1'b1);
      check("hold result", out_result, 32'd42);
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_op = FUNCT_DIVU; in_a = 32'd9; in_b = 32'd0;
      @(posedge clk); #1;
      check("handshake to idle", in_ready, 1'b1);
      check("handshake drops valid", out_valid, 1'b0);
      out_ready = 1'b0;
      @(posedge clk); #1;
      check("accept after handshake", in_ready, 1'b0);
      in_valid = 1'b0;
      wait_valid(10, n, busy_ok);
      check("post-handshake result", out_result, 32'hFFFFFFFF);
      drain();

      // Kill in the middle of a divide.
      start(FUNCT_DIVU, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      @(negedge clk); kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      check("kill to idle", in_ready, 1'b1);
      watch_quiet("kill no result", 40);

      // Kill with a request in IDLE blocks acceptance.
      @(negedge clk);
      kill = 1'b1; in_valid = 1'b1; in_op = FUNCT_MUL; in_a = 32'd3; in_b = 32'd3;
      @(posedge clk); #1;
      check("kill blocks accept", in_ready, 1'b1);
      kill = 1'b0; in_valid = 1'b0;
      watch_quiet("kill accept quiet", 5);

      // Kill while a result waits in DONE.
      start(FUNCT_MUL, 32'd3, 32'd5);
      wait_valid(10, n, busy_ok);
      @(negedge clk); kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      check("kill in done", out_valid, 1'b0);

      // Asynchronous reset mid-divide, then in DONE.
      start(FUNCT_DIV, 32'hFFFFFFF9, 32'd2);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst mid-div in_ready", in_ready, 1'b1);
      @(negedge clk); rst_n = 1'b1;
      watch_quiet("rst mid-div quiet", 40);
      start(FUNCT_MUL, 32'd9, 32'd9);
      wait_valid(10, n, busy_ok);
      check("pre-rst result", out_result, 32'd81);
      #2 rst_n = 1'b0;
      #1;
      check("rst in done valid", out_valid, 1'b0);
      check("rst in done result", out_result, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      run64("DIVU64 2^63/3", FUNCT_DIVU, 64'h8000000000000000, 64'd3, 64'h2AAAAAAAAAAAAAAA, 65);
      run64("MULHU64 ones", FUNCT_MULHU, '1, '1, 64'hFFFFFFFFFFFFFFFE, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
